// File: rtl/pit_pkg.sv
// Shared definitions for the 8253 PIT bus master: op encoding, FSM states,
// control-word layout and the per-byte access plan.
package pit_pkg;

  typedef enum logic [1:0] {
    OP_MODE   = 2'd0,
    OP_CFG    = 2'd1,
    OP_READ   = 2'd2,
    OP_RAW_WR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_BYTE,
    M_RECOV,
    M_DONE
  } mst_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_SETUP,
    C_STROBE,
    C_HOLD
  } cyc_state_e;

  localparam logic [1:0] CTRL_ADDR = 2'd3;

  // Control word bit positions: SC1..SC0, RW1..RW0, M2..M0, BCD
  localparam int CW_SC_LSB  = 6;
  localparam int CW_RW_LSB  = 4;
  localparam int CW_M_LSB   = 1;
  localparam int CW_BCD_BIT = 0;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] wdata;
  } byte_op_t;

  function automatic logic [7:0] ctrl_word(logic [1:0] chan, logic [2:0] mode);
    logic [7:0] cw;
    cw                 = '0;
    cw[CW_SC_LSB +: 2] = chan;
    cw[CW_RW_LSB +: 2] = 2'b11;
    cw[CW_M_LSB +: 3]  = mode;
    cw[CW_BCD_BIT]     = 1'b0;
    return cw;
  endfunction

  function automatic logic [7:0] latch_cmd(logic [1:0] chan);
    logic [7:0] cw;
    cw                 = '0;
    cw[CW_SC_LSB +: 2] = chan;
    return cw;
  endfunction

  function automatic logic [1:0] byte_count(op_e op);
    return (op == OP_CFG || op == OP_READ) ? 2'd3 : 2'd1;
  endfunction

  // Only RAW_WR may address the control port directly.
  function automatic logic req_rejected(op_e op, logic [1:0] chan);
    return (op != OP_RAW_WR) && (chan == CTRL_ADDR);
  endfunction

  function automatic byte_op_t byte_plan(op_e op, logic [1:0] chan, logic [2:0] mode,
                                         logic [15:0] data, logic [1:0] idx);
    byte_op_t b;
    b = '{rd: 1'b0, addr: chan, wdata: data[7:0]};
    case (op)
      OP_MODE: b = '{rd: 1'b0, addr: CTRL_ADDR, wdata: ctrl_word(chan, mode)};
      OP_CFG: begin
        if (idx == 2'd0)      b = '{rd: 1'b0, addr: CTRL_ADDR, wdata: ctrl_word(chan, mode)};
        else if (idx == 2'd1) b = '{rd: 1'b0, addr: chan, wdata: data[7:0]};
        else                  b = '{rd: 1'b0, addr: chan, wdata: data[15:8]};
      end
      OP_READ: begin
        if (idx == 2'd0) b = '{rd: 1'b0, addr: CTRL_ADDR, wdata: latch_cmd(chan)};
        else             b = '{rd: 1'b1, addr: chan, wdata: 8'h00};
      end
      default: b = '{rd: 1'b0, addr: chan, wdata: data[7:0]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pit_bus_master_if.sv
// Host request/response handshake plus the 8253 bus pins, grouped so the
// master and its environment connect through one bundle.
interface pit_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_chan;
  logic [2:0]  req_mode;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        cs_n;
  logic        rd_n;
  logic        wr_n;
  logic        a1;
  logic        a0;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;

  modport master (
    input  req_valid, req_op, req_chan, req_mode, req_data, d_in,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           cs_n, rd_n, wr_n, a1, a0, d_out, d_oe
  );

  modport slave (
    output req_valid, req_op, req_chan, req_mode, req_data, d_in,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           cs_n, rd_n, wr_n, a1, a0, d_out, d_oe
  );
endinterface

// File: rtl/pit_bus_cycle.sv
// Sequences one 8253 byte access: SETUP, STROBE, HOLD, sampling read data
// on the final strobe clock. 'last' flags the final HOLD clock.
module pit_bus_cycle
  import pit_pkg::*;
#(
  parameter int T_SU  = 1,
  parameter int T_STB = 2,
  parameter int T_HLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  byte_op_t   op,
  input  logic [7:0] d_in,
  output logic       last,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a1,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe
);

  cyc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  byte_op_t         op_q;
  logic             active;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) op_q <= op;
      if (state_q == C_STROBE && cnt_q == CNT_W'(T_STB - 1) && op_q.rd) rdata <= d_in;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    last    = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        cnt_d = '0;
        if (start) state_d = C_SETUP;
      end
      C_SETUP: begin
        if (cnt_q == CNT_W'(T_SU - 1)) begin
          state_d = C_STROBE;
          cnt_d   = '0;
        end
      end
      C_STROBE: begin
        if (cnt_q == CNT_W'(T_STB - 1)) begin
          state_d = C_HOLD;
          cnt_d   = '0;
        end
      end
      C_HOLD: begin
        if (cnt_q == CNT_W'(T_HLD - 1)) begin
          state_d = C_IDLE;
          cnt_d   = '0;
          last    = 1'b1;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active    = (state_q != C_IDLE);
  assign cs_n      = !active;
  assign rd_n      = !(state_q == C_STROBE && op_q.rd);
  assign wr_n      = !(state_q == C_STROBE && !op_q.rd);
  assign d_oe      = active && !op_q.rd;
  assign d_out     = d_oe ? op_q.wdata : 8'h00;
  assign {a1, a0}  = active ? op_q.addr : 2'b00;

endmodule

// File: rtl/pit_bus_master.sv
// 8253 PIT bus master: accepts one host request at a time, expands it into
// byte accesses separated by cs_n recovery, and returns a one-clock response.
module pit_bus_master
  import pit_pkg::*;
#(
  parameter int T_SU  = 1,
  parameter int T_STB = 2,
  parameter int T_HLD = 1,
  parameter int T_REC = 1
) (
  input logic               clk,
  input logic               rst,
  pit_bus_master_if.master  bus
);

  mst_state_e       state_q, state_d;
  op_e              op_q, req_op;
  logic [1:0]       chan_q;
  logic [2:0]       mode_q;
  logic [15:0]      data_q;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] rec_q, rec_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q;
  logic             accept, reject, start, last;
  byte_op_t         plan;
  logic [7:0]       cyc_rdata;

  assign req_op        = op_e'(bus.req_op);
  assign bus.req_ready = (state_q == M_IDLE);
  assign accept        = bus.req_valid && (state_q == M_IDLE);
  assign reject        = req_rejected(req_op, bus.req_chan);

  // The first byte launches on the acceptance edge, straight from the request.
  assign plan = (state_q == M_IDLE)
              ? byte_plan(req_op, bus.req_chan, bus.req_mode, bus.req_data, 2'd0)
              : byte_plan(op_q, chan_q, mode_q, data_q, idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M_IDLE;
      idx_q   <= '0;
      rec_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
      err_q   <= err_d;
      if (accept) begin
        rdata_q <= '0;
      end else if (state_q == M_BYTE && last && plan.rd) begin
        if (idx_q == 2'd1) rdata_q[7:0]  <= cyc_rdata;
        else               rdata_q[15:8] <= cyc_rdata;
      end
    end
  end

  // NOTE: captured request fields carry no reset; they are read only after
  // an acceptance has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= req_op;
      chan_q <= bus.req_chan;
      mode_q <= bus.req_mode;
      data_q <= bus.req_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    err_d   = err_q;
    start   = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (accept) begin
          idx_d = 2'd0;
          err_d = reject;
          if (reject) begin
            state_d = M_DONE;
          end else begin
            state_d = M_BYTE;
            start   = 1'b1;
          end
        end
      end
      M_BYTE: begin
        if (last) begin
          if (idx_q == byte_count(op_q) - 2'd1) begin
            state_d = M_DONE;
          end else begin
            state_d = M_RECOV;
            idx_d   = idx_q + 2'd1;
            rec_d   = '0;
          end
        end
      end
      M_RECOV: begin
        if (rec_q == CNT_W'(T_REC - 1)) begin
          state_d = M_BYTE;
          start   = 1'b1;
        end else begin
          rec_d = rec_q + CNT_W'(1);
        end
      end
      M_DONE:  state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  assign bus.rsp_valid = (state_q == M_DONE);
  assign bus.rsp_err   = (state_q == M_DONE) && err_q;
  assign bus.rsp_data  = (state_q == M_DONE) ? rdata_q : 16'h0000;

  pit_bus_cycle #(
    .T_SU  (T_SU),
    .T_STB (T_STB),
    .T_HLD (T_HLD)
  ) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (plan),
    .d_in  (bus.d_in),
    .last  (last),
    .rdata (cyc_rdata),
    .cs_n  (bus.cs_n),
    .rd_n  (bus.rd_n),
    .wr_n  (bus.wr_n),
    .a1    (bus.a1),
    .a0    (bus.a0),
    .d_out (bus.d_out),
    .d_oe  (bus.d_oe)
  );

endmodule

// File: tb/tb_pit_bus_master.sv
// Scoreboard bench for pit_bus_master: a request-level model predicts bus
// transactions and responses; independent monitors compare what the DUT does.
module tb_pit_bus_master;

  localparam int T_SU  = 1;
  localparam int T_STB = 2;
  localparam int T_HLD = 1;
  localparam int T_REC = 1;
  localparam int T_BYTE = T_SU + T_STB + T_HLD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pit_bus_master_if bus_if ();

  pit_bus_master #(
    .T_SU  (T_SU),
    .T_STB (T_STB),
    .T_HLD (T_HLD),
    .T_REC (T_REC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    bit       rd;
    bit [1:0] addr;
    bit [7:0] data;
    bit       first;
  } bus_item_t;

  typedef struct {
    bit        err;
    bit [15:0] data;
    int        cyc;
  } rsp_item_t;

  bus_item_t exp_bus[$];
  rsp_item_t exp_rsp[$];
  bit [7:0]  rd_bytes[$];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  bit aborting = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_bus(bit rd, bit [1:0] addr, bit [7:0] data, bit first);
    bus_item_t it;
    it.rd = rd; it.addr = addr; it.data = data; it.first = first;
    exp_bus.push_back(it);
  endtask

  // Request-level reference: what the 8253 should see and what the host gets back.
  task automatic model_request(bit [1:0] op, bit [1:0] chan, bit [2:0] mode, bit [15:0] data,
                               bit [7:0] lo, bit [7:0] hi, int acc_cyc);
    rsp_item_t r;
    bit [7:0]  cw;
    int        n;
    cw = {chan, 2'b11, mode, 1'b0};
    r.err = 1'b0; r.data = 16'h0; n = 1;
    if (op != 2'd3 && chan == 2'd3) begin
      r.err = 1'b1;
      r.cyc = acc_cyc;
      exp_rsp.push_back(r);
      return;
    end
    case (op)
      2'd0: begin push_bus(1'b0, 2'd3, cw, 1'b1); n = 1; end
      2'd1: begin
        push_bus(1'b0, 2'd3, cw, 1'b1);
        push_bus(1'b0, chan, data[7:0], 1'b0);
        push_bus(1'b0, chan, data[15:8], 1'b0);
        n = 3;
      end
      2'd2: begin
        push_bus(1'b0, 2'd3, {chan, 6'b000000}, 1'b1);
        push_bus(1'b1, chan, 8'h00, 1'b0);
        push_bus(1'b1, chan, 8'h00, 1'b0);
        rd_bytes.push_back(lo);
        rd_bytes.push_back(hi);
        r.data = {hi, lo};
        n = 3;
      end
      default: begin push_bus(1'b0, chan, data[7:0], 1'b1); n = 1; end
    endcase
    r.cyc = acc_cyc + T_BYTE * n + T_REC * (n - 1);
    exp_rsp.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic issue(bit [1:0] op, bit [1:0] chan, bit [2:0] mode, bit [15:0] data,
                       bit [7:0] lo, bit [7:0] hi, bit keep_valid);
    int waited;
    waited = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_chan  = chan;
    bus_if.req_mode  = mode;
    bus_if.req_data  = data;
    while (bus_if.req_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        fail_now("accept_timeout");
        bus_if.req_valid = 1'b0;
        return;
      end
    end
    model_request(op, chan, mode, data, lo, hi, cyc + 1);
    @(negedge clk);
    if (!keep_valid) bus_if.req_valid = 1'b0;
  endtask

  // 8253 read responder: junk until the last strobe clock, then the real byte.
  initial begin : responder
    bit [7:0] b;
    bus_if.d_in = 8'h00;
    forever begin
      @(negedge bus_if.rd_n);
      b = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hEE;
      bus_if.d_in = ~b;
      repeat (T_STB - 1) @(posedge clk);
      #1 bus_if.d_in = b;
      @(posedge bus_if.rd_n);
      bus_if.d_in = 8'($urandom);
    end
  end

  initial begin : bus_mon
    bit        in_txn, saw_rd, saw_wr, stable, oe0;
    int        low_cnt, stb_off, stb_len, gap;
    bit [1:0]  addr0;
    bit [7:0]  dout0, wdata;
    bus_item_t e;
    in_txn = 1'b0; gap = 0;
    low_cnt = 0; stb_off = -1; stb_len = 0;
    saw_rd = 1'b0; saw_wr = 1'b0; stable = 1'b1; oe0 = 1'b0;
    addr0 = 2'd0; dout0 = 8'h00; wdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || aborting) begin
        in_txn = 1'b0;
        gap = 0;
        continue;
      end
      check("dual_strobe", 32'(bus_if.rd_n | bus_if.wr_n), 32'd1);
      if (bus_if.cs_n) check("strobe_without_cs", 32'({bus_if.rd_n, bus_if.wr_n}), 32'd3);
      if (!bus_if.cs_n) begin
        if (!in_txn) begin
          in_txn = 1'b1; low_cnt = 0; stb_off = -1; stb_len = 0;
          saw_rd = 1'b0; saw_wr = 1'b0; stable = 1'b1; wdata = 8'h00;
          addr0 = {bus_if.a1, bus_if.a0}; dout0 = bus_if.d_out; oe0 = bus_if.d_oe;
          if (exp_bus.size() > 0 && !exp_bus[0].first) check("recovery_gap", 32'(gap), 32'(T_REC));
        end
        if ({bus_if.a1, bus_if.a0} != addr0 || bus_if.d_oe != oe0 || (oe0 && bus_if.d_out != dout0))
          stable = 1'b0;
        if (!bus_if.rd_n || !bus_if.wr_n) begin
          if (stb_off < 0) stb_off = low_cnt;
          stb_len++;
          if (!bus_if.rd_n) saw_rd = 1'b1;
          if (!bus_if.wr_n) begin saw_wr = 1'b1; wdata = bus_if.d_out; end
        end
        low_cnt++;
      end else begin
        if (in_txn) begin
          in_txn = 1'b0;
          gap = 0;
          if (exp_bus.size() == 0) begin
            fail_now("unexpected_bus_cycle");
          end else begin
            e = exp_bus.pop_front();
            check("bus_dir", 32'({saw_rd, saw_wr}), e.rd ? 32'd2 : 32'd1);
            check("bus_addr", 32'(addr0), 32'(e.addr));
            if (!e.rd) check("bus_wdata", 32'(wdata), 32'(e.data));
            check("bus_oe", 32'(oe0), 32'(!e.rd));
            check("bus_stable", 32'(stable), 32'd1);
            check("bus_timing", {8'h00, 8'(stb_off), 8'(stb_len), 8'(low_cnt)},
                  {8'h00, 8'(T_SU), 8'(T_STB), 8'(T_BYTE)});
          end
        end
        gap++;
      end
    end
  end

  initial begin : rsp_mon
    rsp_item_t r;
    forever begin
      @(negedge clk);
      if (rst || aborting) continue;
      if (bus_if.rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_err", 32'(bus_if.rsp_err), 32'(r.err));
          check("rsp_data", 32'(bus_if.rsp_data), 32'(r.data));
          check("rsp_latency", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int t, gap_n;
    bit [1:0] op, chan;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'd0;
    bus_if.req_chan  = 2'd0;
    bus_if.req_mode  = 3'd0;
    bus_if.req_data  = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("reset_strobes", 32'({bus_if.cs_n, bus_if.rd_n, bus_if.wr_n}), 32'd7);
    check("reset_addr", 32'({bus_if.a1, bus_if.a0}), 32'd0);
    check("reset_bus_data", 32'({bus_if.d_oe, bus_if.d_out}), 32'd0);
    check("reset_rsp", 32'({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_init", 32'(bus_if.req_ready), 32'd1);

    issue(2'd1, 2'd0, 3'd3, 16'h1234, 8'h00, 8'h00, 1'b0);   // CFG chan0 mode3
    issue(2'd2, 2'd2, 3'd0, 16'h0000, 8'hCD, 8'hAB, 1'b0);   // READ chan2
    issue(2'd3, 2'd1, 3'd0, 16'h005A, 8'h00, 8'h00, 1'b0);   // RAW_WR chan1
    issue(2'd1, 2'd3, 3'd2, 16'hFFFF, 8'h00, 8'h00, 1'b0);   // CFG chan3 rejected
    issue(2'd3, 2'd3, 3'd0, 16'h00C3, 8'h00, 8'h00, 1'b0);   // RAW_WR to control port

    // Reset during the second strobe clock of a CFG.
    issue(2'd1, 2'd0, 3'd2, 16'hBEEF, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_strobes", 32'({bus_if.cs_n, bus_if.rd_n, bus_if.wr_n}), 32'd7);
    check("abort_oe", 32'(bus_if.d_oe), 32'd0);
    check("abort_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    exp_bus.delete();
    exp_rsp.delete();
    rd_bytes.delete();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 32'(bus_if.req_ready), 32'd1);
    aborting = 1'b0;
    issue(2'd0, 2'd1, 3'd2, 16'h0000, 8'h00, 8'h00, 1'b0);   // MODE chan1 mode2

    // req_valid held high across two back-to-back MODE requests.
    issue(2'd0, 2'd0, 3'd1, 16'h0000, 8'h00, 8'h00, 1'b1);
    issue(2'd0, 2'd2, 3'd4, 16'h0000, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 80; i++) begin
      op    = 2'($urandom_range(0, 3));
      chan  = 2'($urandom_range(0, 3));
      gap_n = $urandom_range(0, 3);
      issue(op, chan, 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), gap_n == 0);
      repeat (gap_n) @(negedge clk);
    end

    t = 0;
    while ((exp_rsp.size() > 0 || exp_bus.size() > 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("drain_rsp", 32'(exp_rsp.size()), 32'd0);
    check("drain_bus", 32'(exp_bus.size()), 32'd0);
    check("drain_read_bytes", 32'(rd_bytes.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
